// File: rtl/xsw_pkg.sv
// Shared switch helpers: index-width sizing and one-hot to binary encoding,
// used by both the arbiter side and the response router.
package xsw_pkg;

  localparam int XSW_MAX_N = 32;

  function automatic int xsw_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // OR-combine the indices of set bits: exact for one-hot, 0 for all-zero.
  function automatic logic [4:0] xsw_oh2bin(input logic [XSW_MAX_N-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < XSW_MAX_N; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/xresp_idx_fifo.sv
// In-order tracking FIFO of initiator indices with a registered head output.
module xresp_idx_fifo
  import xsw_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_nxt  = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A write landing in the slot that becomes the head must bypass mem.
      head <= (do_push && (wr_ptr == rd_nxt)) ? din : mem[rd_nxt];
    end
  end

endmodule

// File: rtl/xresp_router.sv
// Response-return router: steers target responses to initiators in grant order.
// Optional macro XRSP_ORPHAN_CHK_EN enables the sticky orphan flag and assertions.
module xresp_router
  import xsw_pkg::*;
#(
  parameter int REQ_N = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_N-1:0]             gnt,
  input  logic                         gnt_fire,
  output logic                         issue_rdy,
  input  logic                         rsp_vld,
  output logic                         rsp_rdy,
  input  logic                         rsp_last,
  input  logic [DW-1:0]                rsp_data,
  output logic [REQ_N-1:0]             ini_rsp_vld,
  input  logic [REQ_N-1:0]             ini_rsp_rdy,
  output logic                         ini_rsp_last,
  output logic [DW-1:0]                ini_rsp_data,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         err_orphan
);

  localparam int IW = xsw_idx_w(REQ_N);

  logic [IW-1:0] push_idx;
  logic [IW-1:0] head;
  logic          full;
  logic          empty;
  logic          pop;

  assign push_idx = IW'(xsw_oh2bin(XSW_MAX_N'(gnt)));

  xresp_idx_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt_fire),
    .din   (push_idx),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

  assign issue_rdy = ~full;

  // Valid/ready: a beat transfers on a cycle where rsp_vld & rsp_rdy; valid
  // never depends on ready, and ready is only offered to the head initiator.
  always_comb begin
    ini_rsp_vld = '0;
    rsp_rdy     = 1'b0;
    if (!empty) begin
      ini_rsp_vld[head] = rsp_vld;
      rsp_rdy           = ini_rsp_rdy[head];
    end
  end

  assign pop          = rsp_vld & rsp_rdy & rsp_last;
  assign ini_rsp_last = rsp_last;
  assign ini_rsp_data = rsp_data;

`ifdef XRSP_ORPHAN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst)                  err_orphan <= 1'b0;
    else if (rsp_vld & empty) err_orphan <= 1'b1;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      a_gnt_onehot0: assert ($onehot0(gnt));
      a_fire_rdy:    assert (!gnt_fire || issue_rdy);
    end
  end
`endif
`else
  assign err_orphan = 1'b0;
`endif

endmodule

// File: tb/tb_xresp_router.sv
// Directed bench for xresp_router with a queue-based tracker model checked
// every cycle, plus literal expectations for each scenario.
module tb_xresp_router;

  localparam int REQ_N = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef XRSP_ORPHAN_CHK_EN
  localparam bit ORPH_EN = 1'b1;
`else
  localparam bit ORPH_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [REQ_N-1:0] gnt;
  logic             gnt_fire;
  logic             issue_rdy;
  logic             rsp_vld;
  logic             rsp_rdy;
  logic             rsp_last;
  logic [DW-1:0]    rsp_data;
  logic [REQ_N-1:0] ini_rsp_vld;
  logic [REQ_N-1:0] ini_rsp_rdy;
  logic             ini_rsp_last;
  logic [DW-1:0]    ini_rsp_data;
  logic [CW-1:0]    outstanding;
  logic             err_orphan;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  int  trk_q[$];
  bit  m_err = 1'b0;
  bit  cmp_en = 1'b0;
  int  xfer_cnt = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  xresp_router #(.REQ_N(REQ_N), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .gnt          (gnt),
    .gnt_fire     (gnt_fire),
    .issue_rdy    (issue_rdy),
    .rsp_vld      (rsp_vld),
    .rsp_rdy      (rsp_rdy),
    .rsp_last     (rsp_last),
    .rsp_data     (rsp_data),
    .ini_rsp_vld  (ini_rsp_vld),
    .ini_rsp_rdy  (ini_rsp_rdy),
    .ini_rsp_last (ini_rsp_last),
    .ini_rsp_data (ini_rsp_data),
    .outstanding  (outstanding),
    .err_orphan   (err_orphan)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic fire_one(input int ini);
    gnt      = 4'(1 << ini);
    gnt_fire = 1'b1;
    exp_q.push_back(2'(ini));
    tick();
    gnt_fire = 1'b0;
    gnt      = '0;
  endtask

  // tracker model: outstanding grants as a plain queue of initiator numbers
  always @(posedge clk) begin
    int sz;
    bit pop_now;
    if (rst) begin
      trk_q.delete();
      m_err = 1'b0;
    end else begin
      sz      = trk_q.size();
      pop_now = (sz > 0) && rsp_vld && ini_rsp_rdy[trk_q[0]] && rsp_last;
      if (ORPH_EN && rsp_vld && sz == 0) m_err = 1'b1;
      if (pop_now) void'(trk_q.pop_front());
      if (gnt_fire && sz < DEPTH)
        for (int i = 0; i < REQ_N; i++) if (gnt[i]) trk_q.push_back(i);
    end
  end

  // per-cycle compare and completion-order scoreboard
  always @(negedge clk) begin
    logic [REQ_N-1:0] e_vld;
    logic             e_rdy;
    if (cmp_en) begin
      e_vld = '0;
      e_rdy = 1'b0;
      if (trk_q.size() > 0) begin
        e_vld[trk_q[0]] = rsp_vld;
        e_rdy           = ini_rsp_rdy[trk_q[0]];
      end
      chk("cyc_ini_vld", ini_rsp_vld, e_vld);
      chk("cyc_rsp_rdy", rsp_rdy, e_rdy);
      chk("cyc_outstanding", outstanding, trk_q.size());
      chk("cyc_issue_rdy", issue_rdy, trk_q.size() < DEPTH);
      chk("cyc_err_orphan", err_orphan, m_err);
      chk("cyc_data", ini_rsp_data, rsp_data);
      chk("cyc_last", ini_rsp_last, rsp_last);
      for (int i = 0; i < REQ_N; i++) begin
        if (ini_rsp_vld[i] && ini_rsp_rdy[i]) begin
          xfer_cnt++;
          if (rsp_last) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL order_extra actual=%0d expected=none at %0t", i, $time);
            end else begin
              chk("order", i, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    int x0;
    int b;
    rst = 1'b1; gnt = '0; gnt_fire = 1'b0;
    rsp_vld = 1'b0; rsp_last = 1'b0; rsp_data = '0; ini_rsp_rdy = 4'b1111;
    tick();
    cmp_en = 1'b1;
    to_neg();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_issue_rdy", issue_rdy, 1);
    chk("rst_rsp_rdy", rsp_rdy, 0);
    chk("rst_ini_vld", ini_rsp_vld, 0);
    chk("rst_err", err_orphan, 0);
    tick();
    rst = 1'b0;
    tick();

    // single transaction
    fire_one(2);
    rsp_vld = 1'b1; rsp_last = 1'b1; rsp_data = 32'hA5A5_0001;
    to_neg();
    chk("single_vld", ini_rsp_vld, 4'b0100);
    chk("single_data", ini_rsp_data, 32'hA5A5_0001);
    chk("single_out1", outstanding, 1);
    chk("single_rdy", rsp_rdy, 1);
    tick();
    rsp_vld = 1'b0; rsp_last = 1'b0;
    to_neg();
    chk("single_out0", outstanding, 0);
    tick();

    // ordering, with a new grant arriving while responses drain
    fire_one(2);
    fire_one(0);
    fire_one(3);
    rsp_vld = 1'b1; rsp_last = 1'b1; rsp_data = 32'h0000_0010;
    gnt = 4'b0010; gnt_fire = 1'b1;
    exp_q.push_back(2'd1);
    tick();
    gnt_fire = 1'b0; gnt = '0;
    for (int k = 1; k < 4; k++) begin
      rsp_data = 32'h0000_0010 + 32'(k);
      tick();
    end
    rsp_vld = 1'b0; rsp_last = 1'b0;
    to_neg();
    chk("order_out0", outstanding, 0);
    tick();

    // multi-beat with toggling ready on initiator 1
    fire_one(1);
    x0 = xfer_cnt;
    b  = 0;
    for (int c = 0; c < 8; c++) begin
      ini_rsp_rdy[1] = (c % 2 == 1);
      rsp_vld  = 1'b1;
      rsp_last = (b == 3);
      rsp_data = 32'hB000_0000 + 32'(b);
      to_neg();
      chk("mb_out_hold", outstanding, 1);
      chk("mb_rdy_mirror", rsp_rdy, ini_rsp_rdy[1]);
      if (ini_rsp_rdy[1]) b++;
      tick();
    end
    rsp_vld = 1'b0; rsp_last = 1'b0; ini_rsp_rdy = 4'b1111;
    to_neg();
    chk("mb_xfers", xfer_cnt - x0, 4);
    chk("mb_out0", outstanding, 0);
    tick();

    // full boundary
    for (int i = 0; i < DEPTH; i++) fire_one(i % REQ_N);
    to_neg();
    chk("full_issue_rdy", issue_rdy, 0);
    chk("full_out", outstanding, DEPTH);
    tick();
`ifndef XRSP_ORPHAN_CHK_EN
    gnt = 4'b0001; gnt_fire = 1'b1;
`endif
    rsp_vld = 1'b1; rsp_last = 1'b1; rsp_data = 32'hC0DE_0000;
    tick();
    gnt_fire = 1'b0; gnt = '0; rsp_vld = 1'b0;
    to_neg();
    chk("full_drop_out", outstanding, DEPTH - 1);
    chk("full_drop_issue", issue_rdy, 1);
    rsp_vld = 1'b1;
    repeat (DEPTH - 1) tick();
    rsp_vld = 1'b0; rsp_last = 1'b0;
    to_neg();
    chk("full_drain_out", outstanding, 0);
    tick();

    // orphan beat
    rsp_vld = 1'b1; rsp_last = 1'b1;
    to_neg();
    chk("orph_rdy", rsp_rdy, 0);
    chk("orph_vld", ini_rsp_vld, 0);
    tick();
    rsp_vld = 1'b0; rsp_last = 1'b0;
    to_neg();
    chk("orph_err", err_orphan, ORPH_EN);
    tick();
    tick();
    to_neg();
    chk("orph_err_held", err_orphan, ORPH_EN);
    tick();

    // reset with three outstanding and a beat in flight
    fire_one(1);
    fire_one(2);
    fire_one(3);
    exp_q.delete();
    rsp_vld = 1'b1; rsp_last = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    to_neg();
    chk("mrst_out", outstanding, 0);
    chk("mrst_issue", issue_rdy, 1);
    chk("mrst_ini_vld", ini_rsp_vld, 0);
    chk("mrst_rsp_rdy", rsp_rdy, 0);
    chk("mrst_err", err_orphan, 0);
    tick();
    rsp_vld = 1'b0;
    to_neg();
    chk("mrst_orphan", err_orphan, ORPH_EN);
    tick();

    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
